// File: rtl/inv_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : inv_mix_columns_seq
// Description : Column-serial AES AddRoundKey + InvMixColumns back-end with
//               valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         key_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int         c_STEPS = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] c_LAST  = 2'(c_STEPS - 1);
    // Truncates to 0 for 4 columns/cycle, so the lane index collapses to the lane number.
    localparam logic [1:0] c_CPC   = 2'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           w_accept;
    logic [1:0]     r_cnt;
    logic [127:0]   r_work;
    logic [127:0]   r_state_out;
    logic           r_out_valid;
    logic [127:0]   w_load;
    logic [127:0]   w_step;
    logic [1:0]     w_idx;
    logic [31:0]    w_col_in  [4];
    logic [31:0]    w_col_out [4];

    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] f_inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = f_xtime(a[i]);
            x4[i] = f_xtime(x2[i]);
            x8[i] = f_xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign w_load = state_in ^ (key_en ? round_key : 128'd0);

    generate
        for (genvar c = 0; c < 4; c++) begin : g_cols
            assign w_col_in[c]           = r_work[127-32*c -: 32];
            assign w_step[127-32*c -: 32] = w_col_out[c];
        end
    endgenerate

    // Only the COLS_PER_CYCLE columns addressed by the counter are rewritten.
    always_comb begin
        w_idx = 2'd0;
        for (int c = 0; c < 4; c++) begin
            w_col_out[c] = w_col_in[c];
        end
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_idx            = r_cnt * c_CPC + 2'(j);
            w_col_out[w_idx] = f_inv_mix_col(w_col_in[w_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == c_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    w_state_next = in_valid ? S_BUSY : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
        w_accept = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_state_out <= '0;
        end else begin
            if (w_accept) begin
                r_work      <= w_load;
                r_cnt       <= '0;
                r_out_valid <= 1'b0;
            end else if (r_state == S_BUSY) begin
                r_work <= w_step;
                if (r_cnt == c_LAST) begin
                    r_cnt       <= '0;
                    r_out_valid <= 1'b1;
                    r_state_out <= w_step;
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end else if (r_state == S_DONE && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign state_out = r_state_out;

endmodule
`default_nettype wire

// File: tb/tb_inv_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_mix_columns_seq
// Description : Bench for inv_mix_columns_seq at 1, 2 and 4 columns per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_mix_columns_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst, iv, ir, ke, ov, orr;
    logic [2:0][127:0] si, rk, so;

    int checks   = 0;
    int failures = 0;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .rst       (rst[g]),
                .in_valid  (iv[g]),
                .in_ready  (ir[g]),
                .state_in  (si[g]),
                .round_key (rk[g]),
                .key_en    (ke[g]),
                .out_valid (ov[g]),
                .out_ready (orr[g]),
                .state_out (so[g])
            );
        end
    endgenerate

    // GF(2^8) product: carry-less multiply, then long division by 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                           input logic kev);
        logic [7:0]   coef [4];
        logic [127:0] st;
        logic [127:0] res;
        logic [7:0]   acc;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        st  = s ^ (kev ? k : 128'd0);
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], st[127-32*c-8*j -: 8]);
                end
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset(input int d);
        rst[d] = 1'b1;
        iv[d]  = 1'b1;
        si[d]  = rnd128();
        tick();
        tick();
        checks++;
        if (ir[d] !== 1'b0) begin
            failures++; $display("FAIL cpc=%0d reset_in_ready got=%b exp=0", 1 << d, ir[d]);
        end
        checks++;
        if (ov[d] !== 1'b0) begin
            failures++; $display("FAIL cpc=%0d reset_out_valid got=%b exp=0", 1 << d, ov[d]);
        end
        checks++;
        if (so[d] !== 128'd0) begin
            failures++; $display("FAIL cpc=%0d reset_state_out got=%h exp=0", 1 << d, so[d]);
        end
        rst[d] = 1'b0;
        iv[d]  = 1'b0;
        tick();
        checks++;
        if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
            failures++;
            $display("FAIL cpc=%0d reset_release got ready=%b valid=%b exp ready=1 valid=0",
                     1 << d, ir[d], ov[d]);
        end
    endtask

    task automatic test_single(input int d, input logic [127:0] s, input logic [127:0] k,
                               input logic kev, input logic [127:0] exp, input string name);
        int n;
        n = 4 >> d;
        orr[d] = 1'b0;
        iv[d]  = 1'b1;
        si[d]  = s;
        rk[d]  = k;
        ke[d]  = kev;
        checks++;
        if (ir[d] !== 1'b1) begin
            failures++; $display("FAIL cpc=%0d %s_idle_ready got=%b exp=1", 1 << d, name, ir[d]);
        end
        tick();
        iv[d] = 1'b0;
        si[d] = ~s;
        rk[d] = rnd128();
        ke[d] = ~kev;
        checks++;
        if (ir[d] !== 1'b0 || ov[d] !== 1'b0) begin
            failures++;
            $display("FAIL cpc=%0d %s_after_accept got ready=%b valid=%b exp 0 0",
                     1 << d, name, ir[d], ov[d]);
        end
        for (int cyc = 1; cyc <= n; cyc++) begin
            tick();
            checks++;
            if (ov[d] !== (cyc == n) || ir[d] !== 1'b0) begin
                failures++;
                $display("FAIL cpc=%0d %s_latency cycle=%0d got valid=%b ready=%b exp valid=%b ready=0",
                         1 << d, name, cyc, ov[d], ir[d], cyc == n);
            end
        end
        checks++;
        if (so[d] !== exp) begin
            failures++; $display("FAIL cpc=%0d %s_data got=%h exp=%h", 1 << d, name, so[d], exp);
        end
        orr[d] = 1'b1;
        #1;
        checks++;
        if (ir[d] !== 1'b1) begin
            failures++; $display("FAIL cpc=%0d %s_done_ready got=%b exp=1", 1 << d, name, ir[d]);
        end
        tick();
        orr[d] = 1'b0;
        checks++;
        if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
            failures++;
            $display("FAIL cpc=%0d %s_drain got valid=%b ready=%b exp valid=0 ready=1",
                     1 << d, name, ov[d], ir[d]);
        end
    endtask

    task automatic test_known_vector(input int d);
        test_single(d, {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6}, rnd128(), 1'b0,
                    {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5}, "t1");
    endtask

    task automatic test_key_add(input int d);
        test_single(d, 128'd0, {32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6, 32'hd5d5d7d6}, 1'b1,
                    {32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6, 32'hd4d4d4d5}, "t2");
    endtask

    task automatic test_random(input int d);
        logic [127:0] s, k;
        logic         kev;
        for (int i = 0; i < 4; i++) begin
            s   = rnd128();
            k   = rnd128();
            kev = 1'($urandom_range(0, 1));
            test_single(d, s, k, kev, model(s, k, kev), "rand");
        end
    endtask

    task automatic test_backpressure(input int d);
        int           n;
        logic [127:0] s, k, exp;
        n   = 4 >> d;
        s   = rnd128();
        k   = rnd128();
        exp = model(s, k, 1'b1);
        orr[d] = 1'b0;
        iv[d]  = 1'b1;
        si[d]  = s;
        rk[d]  = k;
        ke[d]  = 1'b1;
        tick();
        iv[d] = 1'b0;
        for (int cyc = 1; cyc <= n; cyc++) tick();
        for (int h = 0; h < 7; h++) begin
            checks++;
            if (ov[d] !== 1'b1 || so[d] !== exp || ir[d] !== 1'b0) begin
                failures++;
                $display("FAIL cpc=%0d bp_hold cycle=%0d got valid=%b ready=%b data=%h exp 1 0 %h",
                         1 << d, h, ov[d], ir[d], so[d], exp);
            end
            tick();
        end
        orr[d] = 1'b1;
        tick();
        orr[d] = 1'b0;
        for (int cyc = 0; cyc < n + 2; cyc++) begin
            checks++;
            if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
                failures++;
                $display("FAIL cpc=%0d bp_single_transfer cycle=%0d got valid=%b ready=%b exp 0 1",
                         1 << d, cyc, ov[d], ir[d]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back(input int d);
        int           n, got, t, fed;
        bit           pend;
        logic [127:0] xs  [3];
        logic [127:0] xk  [3];
        logic         xe  [3];
        logic [127:0] exq [$];
        n = 4 >> d;
        for (int i = 0; i < 3; i++) begin
            xs[i] = rnd128();
            xk[i] = rnd128();
            xe[i] = 1'($urandom_range(0, 1));
            exq.push_back(model(xs[i], xk[i], xe[i]));
        end
        orr[d] = 1'b1;
        iv[d]  = 1'b1;
        si[d] = xs[0]; rk[d] = xk[0]; ke[d] = xe[0];
        tick();
        si[d] = xs[1]; rk[d] = xk[1]; ke[d] = xe[1];
        fed = 1; got = 0; t = 0; pend = 1'b0;
        while (got < 3 && t < 12 * (n + 1)) begin
            tick();
            t++;
            if (pend) begin
                fed++;
                if (fed < 3) begin
                    si[d] = xs[fed]; rk[d] = xk[fed]; ke[d] = xe[fed];
                end else begin
                    iv[d] = 1'b0;
                end
                pend = 1'b0;
            end
            if (ov[d] === 1'b1) begin
                checks++;
                if (so[d] !== exq[got]) begin
                    failures++;
                    $display("FAIL cpc=%0d b2b_data idx=%0d got=%h exp=%h", 1 << d, got, so[d], exq[got]);
                end
                checks++;
                if (t != n + got * (n + 1)) begin
                    failures++;
                    $display("FAIL cpc=%0d b2b_timing idx=%0d got cycle=%0d exp cycle=%0d",
                             1 << d, got, t, n + got * (n + 1));
                end
                checks++;
                if (ir[d] !== 1'b1) begin
                    failures++; $display("FAIL cpc=%0d b2b_ready idx=%0d got=%b exp=1", 1 << d, got, ir[d]);
                end
                got++;
                pend = 1'b1;
            end
        end
        checks++;
        if (got != 3) begin
            failures++; $display("FAIL cpc=%0d b2b_count got=%0d exp=3", 1 << d, got);
        end
        iv[d] = 1'b0;
        tick();
        orr[d] = 1'b0;
        checks++;
        if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
            failures++;
            $display("FAIL cpc=%0d b2b_idle got valid=%b ready=%b exp 0 1", 1 << d, ov[d], ir[d]);
        end
    endtask

    task automatic test_reset_abort(input int d);
        int n, ra;
        n  = 4 >> d;
        ra = (n < 2) ? n : 2;
        orr[d] = 1'b0;
        iv[d]  = 1'b1;
        si[d]  = rnd128();
        rk[d]  = rnd128();
        ke[d]  = 1'b1;
        tick();
        iv[d] = 1'b0;
        for (int i = 1; i < ra; i++) tick();
        rst[d] = 1'b1;
        tick();
        checks++;
        if (ir[d] !== 1'b0 || ov[d] !== 1'b0) begin
            failures++;
            $display("FAIL cpc=%0d abort_in_reset got ready=%b valid=%b exp 0 0", 1 << d, ir[d], ov[d]);
        end
        rst[d] = 1'b0;
        tick();
        checks++;
        if (ir[d] !== 1'b1 || so[d] !== 128'd0) begin
            failures++;
            $display("FAIL cpc=%0d abort_release got ready=%b data=%h exp ready=1 data=0",
                     1 << d, ir[d], so[d]);
        end
        for (int cyc = 0; cyc < n + 3; cyc++) begin
            checks++;
            if (ov[d] !== 1'b0) begin
                failures++; $display("FAIL cpc=%0d abort_no_output cycle=%0d got=%b exp=0", 1 << d, cyc, ov[d]);
            end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = '1;
        iv  = '0;
        orr = '0;
        ke  = '0;
        si  = '0;
        rk  = '0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            test_reset(d);
            test_known_vector(d);
            test_key_add(d);
            test_random(d);
            test_backpressure(d);
            test_back_to_back(d);
            test_reset_abort(d);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
